// File: rtl/conv_window_buffer.sv
// conv_window_buffer: raster pixel stream to 3x3 windows over two line buffers,
// plus the weight/exponent-bias registers feeding the MAC.
module conv_window_buffer #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  pix_in,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic        cfg_load,
  input  logic [35:0] weight_in,
  input  logic [4:0]  exp_bias_in,
  output logic        cfg_ack,
  output logic        win_valid,
  input  logic        win_ready,
  output logic [71:0] image_out,
  output logic [35:0] weight_out,
  output logic [4:0]  exp_bias_out,
  output logic        frame_done
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [0:2][0:2][7:0] win_q, win_d, img_q, img_d;
  logic win_valid_q, win_valid_d, cfg_ack_q, cfg_ack_d;
  logic [35:0] weight_q, weight_d;
  logic [4:0] bias_q, bias_d;
  logic [7:0] line0_q [IMG_W];
  logic [7:0] line1_q [IMG_W];
  logic accept, col_last, row_last, emit, cfg_ok;
  assign pix_ready = (!win_valid_q || win_ready) && state_q != DRAIN;
  assign accept = pix_valid && pix_ready;
  assign col_last = col_q == CW'(IMG_W - 1);
  assign row_last = row_q == RW'(IMG_H - 1);
  assign emit = accept && row_q >= RW'(2) && col_q >= CW'(2);
  assign cfg_ok = cfg_load && state_q == IDLE;
  // DRAIN holds only the last window, so any handshake there ends the frame
  assign frame_done = state_q == DRAIN && win_valid_q && win_ready;
  assign cfg_ack = cfg_ack_q;
  assign win_valid = win_valid_q;
  assign image_out = img_q;
  assign weight_out = weight_q;
  assign exp_bias_out = bias_q;
  always_comb begin
    col_d = accept ? (col_last ? '0 : col_q + 1'b1) : col_q;
    row_d = (accept && col_last) ? (row_last ? '0 : row_q + 1'b1) : row_q;
    win_d = accept ? {win_q[0][1], win_q[0][2], line0_q[col_q],
                      win_q[1][1], win_q[1][2], line1_q[col_q],
                      win_q[2][1], win_q[2][2], pix_in} : win_q;
    img_d = emit ? win_d : img_q;
    win_valid_d = emit || (win_valid_q && !win_ready);
    cfg_ack_d = cfg_ok;
    weight_d = cfg_ok ? weight_in : weight_q;
    bias_d = cfg_ok ? exp_bias_in : bias_q;
    state_d = (state_q == IDLE)   ? (accept ? ACTIVE : IDLE) :
              (state_q == ACTIVE) ? ((accept && row_last && col_last) ? DRAIN : ACTIVE) :
                                    (frame_done ? IDLE : DRAIN);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      col_q <= '0;
      row_q <= '0;
      win_q <= '0;
      img_q <= '0;
      win_valid_q <= 1'b0;
      cfg_ack_q <= 1'b0;
      weight_q <= '0;
      bias_q <= '0;
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      row_q <= row_d;
      win_q <= win_d;
      img_q <= img_d;
      win_valid_q <= win_valid_d;
      cfg_ack_q <= cfg_ack_d;
      weight_q <= weight_d;
      bias_q <= bias_d;
    end
  end
  always_ff @(posedge clk) begin
    if (accept) begin
      line0_q[col_q] <= line1_q[col_q];
      line1_q[col_q] <= pix_in;
    end
  end
endmodule
